// File: rtl/dmi_uncore_mailbox.sv
// Uncore DMI mailbox: a debugger-to-SoC (TX) FIFO, a SoC-to-debugger (RX) FIFO,
// sticky overflow/underflow flags and a scratch register behind the 0x60-0x7F aperture.
module dmi_uncore_mailbox #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic        core_clk,
    input  logic        core_rst_n,
    input  logic        dmi_uncore_en,
    input  logic        dmi_uncore_wr_en,
    input  logic [6:0]  dmi_uncore_addr,
    input  logic [31:0] dmi_uncore_wdata,
    output logic [31:0] dmi_uncore_rdata,
    output logic        soc_rvalid,
    output logic [31:0] soc_rdata,
    input  logic        soc_rready,
    input  logic        soc_wvalid,
    input  logic [31:0] soc_wdata,
    output logic        soc_wready
);
    localparam int PW = $clog2(DEPTH);

    localparam logic [6:0] ADDR_TXDATA  = 7'h60;
    localparam logic [6:0] ADDR_RXDATA  = 7'h61;
    localparam logic [6:0] ADDR_STATUS  = 7'h62;
    localparam logic [6:0] ADDR_SCRATCH = 7'h63;

    logic [31:0]   tx_mem [DEPTH];
    logic [31:0]   rx_mem [DEPTH];
    logic [PW-1:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
    logic [CW-1:0] tx_count, rx_count;
    logic          ovf, unf;
    logic [31:0]   scratch;

    logic tx_full, tx_empty, rx_full, rx_empty;
    logic rd_access, wr_access;
    logic tx_push, tx_pop, rx_push, rx_pop;
    logic ovf_set, unf_set, ovf_clr, unf_clr;
    logic [31:0] status;
    logic [31:0] rdata_next;

    assign tx_full  = (tx_count == CW'(DEPTH));
    assign tx_empty = (tx_count == '0);
    assign rx_full  = (rx_count == CW'(DEPTH));
    assign rx_empty = (rx_count == '0);

    assign rd_access = dmi_uncore_en & ~dmi_uncore_wr_en;
    assign wr_access = dmi_uncore_en &  dmi_uncore_wr_en;

    // SoC side is valid/ready: a word moves in any cycle where both are high.
    // Ready/valid depend only on the current counts, so a pop never frees a slot
    // for a push in the same cycle.
    assign soc_rvalid = ~tx_empty;
    assign soc_rdata  = tx_mem[tx_rd_ptr];
    assign soc_wready = ~rx_full;

    assign tx_push = wr_access & (dmi_uncore_addr == ADDR_TXDATA) & ~tx_full;
    assign tx_pop  = soc_rvalid & soc_rready;
    assign rx_push = soc_wvalid & soc_wready;
    assign rx_pop  = rd_access & (dmi_uncore_addr == ADDR_RXDATA) & ~rx_empty;

    assign ovf_set = wr_access & (dmi_uncore_addr == ADDR_TXDATA) & tx_full;
    assign unf_set = rd_access & (dmi_uncore_addr == ADDR_RXDATA) & rx_empty;
    assign ovf_clr = wr_access & (dmi_uncore_addr == ADDR_STATUS) & dmi_uncore_wdata[18];
    assign unf_clr = wr_access & (dmi_uncore_addr == ADDR_STATUS) & dmi_uncore_wdata[19];

    always_comb begin
        status             = '0;
        status[CW-1:0]     = tx_count;
        status[8+CW-1:8]   = rx_count;
        status[16]         = tx_full;
        status[17]         = rx_empty;
        status[18]         = ovf;
        status[19]         = unf;
    end

    always_comb begin
        rdata_next = '0;
        case (dmi_uncore_addr)
            ADDR_RXDATA:  rdata_next = rx_empty ? 32'h0 : rx_mem[rx_rd_ptr];
            ADDR_STATUS:  rdata_next = status;
            ADDR_SCRATCH: rdata_next = scratch;
            default:      rdata_next = '0;
        endcase
    end

    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tx_mem[i] <= '0;
                rx_mem[i] <= '0;
            end
            tx_wr_ptr        <= '0;
            tx_rd_ptr        <= '0;
            rx_wr_ptr        <= '0;
            rx_rd_ptr        <= '0;
            tx_count         <= '0;
            rx_count         <= '0;
            ovf              <= 1'b0;
            unf              <= 1'b0;
            scratch          <= '0;
            dmi_uncore_rdata <= '0;
        end else begin
            if (tx_push) begin
                tx_mem[tx_wr_ptr] <= dmi_uncore_wdata;
                tx_wr_ptr         <= tx_wr_ptr + PW'(1);
            end
            if (tx_pop) tx_rd_ptr <= tx_rd_ptr + PW'(1);
            if (tx_push && !tx_pop)      tx_count <= tx_count + CW'(1);
            else if (!tx_push && tx_pop) tx_count <= tx_count - CW'(1);

            if (rx_push) begin
                rx_mem[rx_wr_ptr] <= soc_wdata;
                rx_wr_ptr         <= rx_wr_ptr + PW'(1);
            end
            if (rx_pop) rx_rd_ptr <= rx_rd_ptr + PW'(1);
            if (rx_push && !rx_pop)      rx_count <= rx_count + CW'(1);
            else if (!rx_push && rx_pop) rx_count <= rx_count - CW'(1);

            // Set has priority over a same-cycle W1C.
            if (ovf_set)      ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
            if (unf_set)      unf <= 1'b1;
            else if (unf_clr) unf <= 1'b0;

            if (wr_access && dmi_uncore_addr == ADDR_SCRATCH) scratch <= dmi_uncore_wdata;
            if (rd_access) dmi_uncore_rdata <= rdata_next;
        end
    end
endmodule

// File: tb/tb_dmi_uncore_mailbox.sv
// Directed bench for dmi_uncore_mailbox (DEPTH=4) with hand-computed expectations.
module tb_dmi_uncore_mailbox;
    logic        core_clk = 1'b0;
    logic        core_rst_n = 1'b0;
    logic        dmi_uncore_en = 1'b0;
    logic        dmi_uncore_wr_en = 1'b0;
    logic [6:0]  dmi_uncore_addr = '0;
    logic [31:0] dmi_uncore_wdata = '0;
    logic [31:0] dmi_uncore_rdata;
    logic        soc_rvalid;
    logic [31:0] soc_rdata;
    logic        soc_rready = 1'b0;
    logic        soc_wvalid = 1'b0;
    logic [31:0] soc_wdata = '0;
    logic        soc_wready;

    int tests = 0;
    int failures = 0;

    dmi_uncore_mailbox #(.DEPTH(4)) dut (
        .core_clk         (core_clk),
        .core_rst_n       (core_rst_n),
        .dmi_uncore_en    (dmi_uncore_en),
        .dmi_uncore_wr_en (dmi_uncore_wr_en),
        .dmi_uncore_addr  (dmi_uncore_addr),
        .dmi_uncore_wdata (dmi_uncore_wdata),
        .dmi_uncore_rdata (dmi_uncore_rdata),
        .soc_rvalid       (soc_rvalid),
        .soc_rdata        (soc_rdata),
        .soc_rready       (soc_rready),
        .soc_wvalid       (soc_wvalid),
        .soc_wdata        (soc_wdata),
        .soc_wready       (soc_wready)
    );

    always #5 core_clk = ~core_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Each access occupies one cycle, driven and sampled at the falling edge.
    task automatic dmi_write(input logic [6:0] addr, input logic [31:0] data);
        dmi_uncore_en = 1'b1; dmi_uncore_wr_en = 1'b1;
        dmi_uncore_addr = addr; dmi_uncore_wdata = data;
        @(negedge core_clk);
        dmi_uncore_en = 1'b0; dmi_uncore_wr_en = 1'b0;
    endtask

    task automatic dmi_read_check(input string tag, input logic [6:0] addr, input logic [31:0] exp);
        dmi_uncore_en = 1'b1; dmi_uncore_wr_en = 1'b0; dmi_uncore_addr = addr;
        @(negedge core_clk);
        dmi_uncore_en = 1'b0;
        check(tag, dmi_uncore_rdata, exp);
    endtask

    task automatic soc_push(input logic [31:0] data);
        soc_wvalid = 1'b1; soc_wdata = data;
        @(negedge core_clk);
        soc_wvalid = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge core_clk);
        core_rst_n = 1'b1;
        @(negedge core_clk);

        check("reset_rdata", dmi_uncore_rdata, 32'h0);
        check("reset_rvalid", {31'b0, soc_rvalid}, 32'd0);
        check("reset_wready", {31'b0, soc_wready}, 32'd1);
        check("reset_soc_rdata", soc_rdata, 32'h0);
        dmi_read_check("reset_status", 7'h62, 32'h0002_0000);

        // TX fill, overflow, and SoC drain
        dmi_write(7'h60, 32'hA5A5_0001);
        check("tx_rvalid_rise", {31'b0, soc_rvalid}, 32'd1);
        check("tx_head_first", soc_rdata, 32'hA5A5_0001);
        dmi_write(7'h60, 32'hA5A5_0002);
        dmi_write(7'h60, 32'hA5A5_0003);
        dmi_write(7'h60, 32'hA5A5_0004);
        dmi_write(7'h60, 32'hDEAD_BEEF);
        dmi_read_check("tx_full_ovf_status", 7'h62, 32'h0007_0004);
        dmi_read_check("txdata_reads_zero", 7'h60, 32'h0);
        soc_rready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("tx_drain_valid", {31'b0, soc_rvalid}, 32'd1);
            check("tx_drain_data", soc_rdata, 32'hA5A5_0000 + 32'(i));
            @(negedge core_clk);
        end
        soc_rready = 1'b0;
        check("tx_drained_rvalid", {31'b0, soc_rvalid}, 32'd0);

        // RX path, underflow, W1C
        soc_push(32'h1111_1111);
        soc_push(32'h2222_2222);
        dmi_read_check("rx_pop_1", 7'h61, 32'h1111_1111);
        dmi_read_check("rx_pop_2", 7'h61, 32'h2222_2222);
        dmi_read_check("rx_pop_empty", 7'h61, 32'h0);
        dmi_read_check("ovf_unf_status", 7'h62, 32'h000E_0000);
        dmi_write(7'h62, 32'h000C_0000);
        check("write_keeps_rdata", dmi_uncore_rdata, 32'h000E_0000);
        dmi_read_check("w1c_status", 7'h62, 32'h0002_0000);

        // RX full with simultaneous SoC push and DMI pop
        for (int i = 1; i <= 4; i++) soc_push(32'h3000_0000 + 32'(i));
        check("rx_full_wready", {31'b0, soc_wready}, 32'd0);
        dmi_read_check("rx_full_status", 7'h62, 32'h0000_0400);
        soc_wvalid = 1'b1; soc_wdata = 32'h0000_0BAD;
        dmi_read_check("rx_pop_while_full", 7'h61, 32'h3000_0001);
        soc_wvalid = 1'b0;
        check("rx_wready_after_pop", {31'b0, soc_wready}, 32'd1);
        dmi_read_check("rx_count_3", 7'h62, 32'h0000_0300);
        dmi_read_check("rx_rest_2", 7'h61, 32'h3000_0002);
        dmi_read_check("rx_rest_3", 7'h61, 32'h3000_0003);
        dmi_read_check("rx_rest_4", 7'h61, 32'h3000_0004);
        dmi_read_check("rx_empty_again", 7'h62, 32'h0002_0000);

        // Scratch and unmapped addresses
        dmi_write(7'h63, 32'hCAFE_F00D);
        dmi_read_check("scratch_rw", 7'h63, 32'hCAFE_F00D);
        dmi_read_check("unmapped_7f", 7'h7F, 32'h0);
        dmi_write(7'h70, 32'hFFFF_FFFF);
        dmi_read_check("unmapped_wr_status", 7'h62, 32'h0002_0000);
        dmi_read_check("unmapped_wr_scratch", 7'h63, 32'hCAFE_F00D);
        dmi_write(7'h61, 32'h1234_5678);
        dmi_read_check("rxdata_write_ignored", 7'h62, 32'h0002_0000);

        // Mid-operation reset
        dmi_write(7'h60, 32'h4444_0001);
        dmi_write(7'h60, 32'h4444_0002);
        soc_push(32'h5555_0001);
        soc_push(32'h5555_0002);
        dmi_read_check("pre_reset_status", 7'h62, 32'h0000_0202);
        dmi_uncore_en = 1'b1; dmi_uncore_wr_en = 1'b1;
        dmi_uncore_addr = 7'h63; dmi_uncore_wdata = 32'h1234_5678;
        core_rst_n = 1'b0;
        @(negedge core_clk);
        dmi_uncore_en = 1'b0; dmi_uncore_wr_en = 1'b0;
        check("rst_rdata", dmi_uncore_rdata, 32'h0);
        check("rst_rvalid", {31'b0, soc_rvalid}, 32'd0);
        check("rst_soc_rdata", soc_rdata, 32'h0);
        check("rst_wready", {31'b0, soc_wready}, 32'd1);
        core_rst_n = 1'b1;
        @(negedge core_clk);
        dmi_read_check("rst_status", 7'h62, 32'h0002_0000);
        dmi_read_check("rst_scratch", 7'h63, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
